// File: rtl/axis_loopback_param.sv
// axis_loopback_param: AXI-Stream loopback with cut-through, store-and-forward and sink modes.
// One ingress FSM steers packets into a single ordered FIFO; egress gates SAF packets on completeness.
module axis_loopback_param #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [DATA_W-1:0]   S_AXIS_DAT_TDATA,
    input  logic                S_AXIS_DAT_TVALID,
    input  logic [DATA_W/8-1:0] S_AXIS_DAT_TSTRB,
    input  logic [31:0]         S_AXIS_DAT_TUSER,
    input  logic                S_AXIS_DAT_TLAST,
    output logic                S_AXIS_DAT_TREADY,
    output logic [DATA_W-1:0]   M_AXIS_DAT_TDATA,
    output logic [DATA_W/8-1:0] M_AXIS_DAT_TSTRB,
    output logic                M_AXIS_DAT_TLAST,
    output logic                M_AXIS_DAT_TVALID,
    output logic [7:0]          M_AXIS_DAT_TUSER,
    input  logic                M_AXIS_DAT_TREADY,
    input  logic [1:0]          MODE,
    output logic [CNT_W-1:0]    PKT_COUNT,
    output logic [CNT_W-1:0]    DROP_COUNT,
    output logic                OVERFLOW
);
    localparam int SW = DATA_W / 8;
    localparam int EW = DATA_W + SW + 10;
    localparam int PW = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, FWD, SINK} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_saf;
    logic [7:0]       r_op;
    logic [EW-1:0]    r_mem [1<<DEPTH_LOG2];
    logic [PW-1:0]    r_wptr, r_rptr, r_cmpl;
    logic             r_release, r_ovf;
    logic [CNT_W-1:0] r_pkt, r_drop;

    logic          w_sink, w_s_hs, w_push, w_pop, w_full, w_empty, w_force, w_m_valid;
    logic          w_saf, w_head_saf, w_head_last;
    logic [7:0]    w_op;
    logic [PW-1:0] w_used;
    logic [EW-1:0] w_head;
    logic          w_unused;

    assign w_unused    = &{1'b0, S_AXIS_DAT_TUSER[31:8]};
    assign w_used      = r_wptr - r_rptr;
    assign w_full      = w_used == PW'(1 << DEPTH_LOG2);
    assign w_empty     = w_used == '0;
    assign w_head      = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    assign w_head_saf  = w_head[EW-1];
    assign w_head_last = w_head[DATA_W+SW];
    // A full FIFO whose head SAF packet can never complete is released cut-through.
    assign w_force     = w_full && w_head_saf && r_cmpl == '0;
    assign w_m_valid   = !w_empty && (!w_head_saf || r_cmpl != '0 || r_release || w_force);
    assign w_pop       = w_m_valid && M_AXIS_DAT_TREADY;

    always_comb begin
        w_state_nxt       = r_state;
        w_sink            = r_state == SINK || (r_state == IDLE && MODE[1]);
        S_AXIS_DAT_TREADY = ARESETN && (w_sink || !w_full);
        w_s_hs            = S_AXIS_DAT_TVALID && S_AXIS_DAT_TREADY;
        w_push            = w_s_hs && !w_sink;
        w_saf             = r_state == IDLE ? MODE == 2'd1 : r_saf;
        w_op              = r_state == IDLE ? S_AXIS_DAT_TUSER[7:0] : r_op;
        if (w_s_hs)
            w_state_nxt = S_AXIS_DAT_TLAST ? IDLE : r_state == IDLE ? (MODE[1] ? SINK : FWD) : r_state;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
            r_saf   <= 1'b0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_s_hs && r_state == IDLE) begin
                r_saf <= MODE == 2'd1;
                r_op  <= S_AXIS_DAT_TUSER[7:0];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push)
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= {w_saf, w_op, S_AXIS_DAT_TLAST, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TDATA};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cmpl    <= '0;
            r_release <= 1'b0;
            r_ovf     <= 1'b0;
            r_pkt     <= '0;
            r_drop    <= '0;
        end else begin
            r_wptr    <= r_wptr + PW'(w_push);
            r_rptr    <= r_rptr + PW'(w_pop);
            r_cmpl    <= r_cmpl + PW'(w_push && S_AXIS_DAT_TLAST) - PW'(w_pop && w_head_last);
            r_release <= (w_pop && w_head_last) ? 1'b0 : (r_release || w_force);
            r_ovf     <= r_ovf || w_force;
            r_pkt     <= r_pkt + CNT_W'(w_pop && w_head_last);
            r_drop    <= r_drop + CNT_W'(w_s_hs && w_sink && S_AXIS_DAT_TLAST);
        end
    end

    assign M_AXIS_DAT_TVALID = w_m_valid;
    assign M_AXIS_DAT_TDATA  = w_m_valid ? w_head[DATA_W-1:0] : '0;
    assign M_AXIS_DAT_TSTRB  = w_m_valid ? w_head[DATA_W +: SW] : '0;
    assign M_AXIS_DAT_TLAST  = w_m_valid && w_head_last;
    assign M_AXIS_DAT_TUSER  = w_m_valid ? w_head[DATA_W+SW+1 +: 8] : '0;
    assign PKT_COUNT         = r_pkt;
    assign DROP_COUNT        = r_drop;
    assign OVERFLOW          = r_ovf;
endmodule

// File: tb/tb_axis_loopback_param.sv
// tb_axis_loopback_param: directed bench for axis_loopback_param.
// Instance a uses a 16-deep FIFO, instance b a 4-deep FIFO; sel picks which one the stimulus drives.
module tb_axis_loopback_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0, s_user = '0;
    logic [3:0]  s_strb = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, sel = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic        a_s_ready, a_m_valid, a_m_last, a_ovf, b_s_ready, b_m_valid, b_m_last, b_ovf;
    logic [31:0] a_m_data, b_m_data;
    logic [3:0]  a_m_strb, b_m_strb;
    logic [7:0]  a_m_user, b_m_user;
    logic [15:0] a_pkt, a_drop, b_pkt, b_drop;

    logic        s_ready, m_valid, m_last, ovf;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic [7:0]  m_user;
    logic [15:0] pkt, drop;

    int errors = 0, checks = 0, cyc = 0, vld_cycles = 0;
    logic [31:0] rx_data[$];
    logic [3:0]  rx_strb[$];
    logic [7:0]  rx_user[$];
    logic        rx_last[$];
    int          rx_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_loopback_param dut_a (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_DAT_TDATA(s_data), .S_AXIS_DAT_TVALID(s_valid && !sel), .S_AXIS_DAT_TSTRB(s_strb),
        .S_AXIS_DAT_TUSER(s_user), .S_AXIS_DAT_TLAST(s_last), .S_AXIS_DAT_TREADY(a_s_ready),
        .M_AXIS_DAT_TDATA(a_m_data), .M_AXIS_DAT_TSTRB(a_m_strb), .M_AXIS_DAT_TLAST(a_m_last),
        .M_AXIS_DAT_TVALID(a_m_valid), .M_AXIS_DAT_TUSER(a_m_user), .M_AXIS_DAT_TREADY(m_ready && !sel),
        .MODE(mode), .PKT_COUNT(a_pkt), .DROP_COUNT(a_drop), .OVERFLOW(a_ovf));

    axis_loopback_param #(.DEPTH_LOG2(2)) dut_b (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_DAT_TDATA(s_data), .S_AXIS_DAT_TVALID(s_valid && sel), .S_AXIS_DAT_TSTRB(s_strb),
        .S_AXIS_DAT_TUSER(s_user), .S_AXIS_DAT_TLAST(s_last), .S_AXIS_DAT_TREADY(b_s_ready),
        .M_AXIS_DAT_TDATA(b_m_data), .M_AXIS_DAT_TSTRB(b_m_strb), .M_AXIS_DAT_TLAST(b_m_last),
        .M_AXIS_DAT_TVALID(b_m_valid), .M_AXIS_DAT_TUSER(b_m_user), .M_AXIS_DAT_TREADY(m_ready && sel),
        .MODE(mode), .PKT_COUNT(b_pkt), .DROP_COUNT(b_drop), .OVERFLOW(b_ovf));

    assign s_ready = sel ? b_s_ready : a_s_ready;
    assign m_valid = sel ? b_m_valid : a_m_valid;
    assign m_last  = sel ? b_m_last  : a_m_last;
    assign m_data  = sel ? b_m_data  : a_m_data;
    assign m_strb  = sel ? b_m_strb  : a_m_strb;
    assign m_user  = sel ? b_m_user  : a_m_user;
    assign pkt     = sel ? b_pkt     : a_pkt;
    assign drop    = sel ? b_drop    : a_drop;
    assign ovf     = sel ? b_ovf     : a_ovf;

    // Inputs only change just after a rising edge, so the falling edge sees the handshake that follows.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_strb.push_back(m_strb);
            rx_user.push_back(m_user);
            rx_last.push_back(m_last);
            rx_cyc.push_back(cyc);
        end
        if (m_valid) vld_cycles++;
    end

    task automatic clear_rx();
        rx_data.delete(); rx_strb.delete(); rx_user.delete(); rx_last.delete(); rx_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [7:0] op, input logic last,
                             output int acc, output int waits);
        s_data = d; s_strb = d[3:0]; s_user = {16'h00C0, 8'h00, op}; s_last = last; s_valid = 1'b1;
        acc = -1; waits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin acc = cyc; break; end
            waits++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL ingress_timeout: beat %0h never accepted", d);
        end
    endtask

    task automatic test_reset();
        mode = 2'd2; m_ready = 1'b1;
        idle(3);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            checks++;
            if ({s_ready, m_valid, m_last, ovf, m_data, m_strb, m_user, pkt, drop} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b vld=%b last=%b ovf=%b data=%h strb=%h user=%h pkt=%0d drop=%0d, want all 0",
                         s, s_ready, m_valid, m_last, ovf, m_data, m_strb, m_user, pkt, drop);
            end
        end
        sel = 1'b0; mode = 2'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_cut_through();
        int acc0, acc, w;
        logic [31:0] d[3];
        d[0] = 32'h0000_0011; d[1] = 32'h0000_0022; d[2] = 32'h0000_0033;
        sel = 1'b0; mode = 2'd0; m_ready = 1'b1; clear_rx();
        send_beat(d[0], 8'h5A, 1'b0, acc0, w);
        send_beat(d[1], 8'h00, 1'b0, acc, w);
        send_beat(d[2], 8'h00, 1'b1, acc, w);
        idle(4);
        checks++;
        if (rx_data.size() !== 3) begin errors++; $display("FAIL ct_count: got %0d beats, want 3", rx_data.size()); end
        for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_strb[i], rx_user[i], rx_last[i]} !== {d[i], d[i][3:0], 8'h5A, i == 2}) begin
                errors++;
                $display("FAIL ct_beat[%0d]: got data=%h strb=%h user=%h last=%b, want data=%h strb=%h user=5a last=%b",
                         i, rx_data[i], rx_strb[i], rx_user[i], rx_last[i], d[i], d[i][3:0], i == 2);
            end
            checks++;
            if (rx_cyc[i] !== acc0 + 1 + i) begin
                errors++;
                $display("FAIL ct_latency[%0d]: got cycle %0d, want %0d", i, rx_cyc[i], acc0 + 1 + i);
            end
        end
        checks++;
        if (pkt !== 16'd1) begin errors++; $display("FAIL ct_pkt_count: got %0d, want 1", pkt); end
    endtask

    task automatic test_store_forward();
        int acc, w, v0;
        sel = 1'b0; mode = 2'd1; m_ready = 1'b1; clear_rx();
        v0 = vld_cycles;
        send_beat(32'h0000_0101, 8'hC3, 1'b0, acc, w);
        send_beat(32'h0000_0102, 8'h11, 1'b0, acc, w);
        idle(2);
        send_beat(32'h0000_0103, 8'h11, 1'b0, acc, w);
        send_beat(32'h0000_0104, 8'h11, 1'b1, acc, w);
        checks++;
        if (vld_cycles !== v0) begin errors++; $display("FAIL saf_early_valid: got %0d valid cycles before TLAST, want 0", vld_cycles - v0); end
        idle(6);
        checks++;
        if (rx_data.size() !== 4) begin errors++; $display("FAIL saf_count: got %0d beats, want 4", rx_data.size()); end
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_user[i], rx_last[i], rx_cyc[i]} !== {32'h101 + i, 8'hC3, i == 3, acc + 1 + i}) begin
                errors++;
                $display("FAIL saf_beat[%0d]: got data=%h user=%h last=%b cyc=%0d, want data=%h user=c3 last=%b cyc=%0d",
                         i, rx_data[i], rx_user[i], rx_last[i], rx_cyc[i], 32'h101 + i, i == 3, acc + 1 + i);
            end
        end
        checks++;
        if (pkt !== 16'd2) begin errors++; $display("FAIL saf_pkt_count: got %0d, want 2", pkt); end
    endtask

    task automatic test_sink();
        int acc, w, tot, v0;
        sel = 1'b0; mode = 2'd2; m_ready = 1'b1; clear_rx();
        v0 = vld_cycles; tot = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 5; i++) begin
                send_beat(32'h0000_0200 + 32'(p * 16 + i), 8'h66, i == 4, acc, w);
                tot += w;
            end
        idle(4);
        checks++;
        if (tot !== 0) begin errors++; $display("FAIL sink_ready: got %0d stall cycles, want 0", tot); end
        checks++;
        if (vld_cycles !== v0) begin errors++; $display("FAIL sink_valid: got %0d valid cycles, want 0", vld_cycles - v0); end
        checks++;
        if (drop !== 16'd2) begin errors++; $display("FAIL sink_drop_count: got %0d, want 2", drop); end
        checks++;
        if (pkt !== 16'd2) begin errors++; $display("FAIL sink_pkt_count: got %0d, want 2", pkt); end
        mode = 2'd0;
    endtask

    task automatic test_overflow();
        int acc, w[7];
        sel = 1'b1; mode = 2'd1; m_ready = 1'b1; clear_rx();
        for (int i = 0; i < 7; i++) send_beat(32'h0000_00A0 + 32'(i), 8'h77, i == 6, acc, w[i]);
        idle(10);
        checks++;
        if (w[0] + w[1] + w[2] + w[3] !== 0 || w[4] == 0) begin
            errors++;
            $display("FAIL ovf_stall: got waits %0d %0d %0d %0d %0d, want 0 0 0 0 >0", w[0], w[1], w[2], w[3], w[4]);
        end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, want 1", ovf); end
        checks++;
        if (rx_data.size() !== 7) begin errors++; $display("FAIL ovf_count: got %0d beats, want 7", rx_data.size()); end
        for (int i = 0; i < 7 && i < rx_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_user[i], rx_last[i]} !== {32'hA0 + i, 8'h77, i == 6}) begin
                errors++;
                $display("FAIL ovf_beat[%0d]: got data=%h user=%h last=%b, want data=%h user=77 last=%b",
                         i, rx_data[i], rx_user[i], rx_last[i], 32'hA0 + i, i == 6);
            end
        end
        checks++;
        if (pkt !== 16'd1) begin errors++; $display("FAIL ovf_pkt_count: got %0d, want 1", pkt); end
        sel = 1'b0; mode = 2'd0;
    endtask

    task automatic test_back_to_back();
        int acc, w, tot, rdy;
        sel = 1'b0; mode = 2'd0; m_ready = 1'b0; clear_rx(); tot = 0; rdy = 0;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h0000_0B00 + 32'(i), i == 0 ? 8'h3C : 8'hEE, 1'b0, acc, w);
            tot += w;
        end
        s_data = 32'h0000_0B10; s_strb = 4'h0; s_last = 1'b0; s_valid = 1'b1;
        repeat (5) begin @(negedge clk); rdy += int'(s_ready); end
        checks++;
        if (tot !== 0 || rdy !== 0) begin
            errors++;
            $display("FAIL full_stall: got %0d stalls in 16 beats and %0d ready cycles when full, want 0 and 0", tot, rdy);
        end
        checks++;
        if ({m_valid, m_data, m_user} !== {1'b1, 32'h0000_0B00, 8'h3C}) begin
            errors++;
            $display("FAIL full_head: got vld=%b data=%h user=%h, want vld=1 data=00000b00 user=3c", m_valid, m_data, m_user);
        end
        @(posedge clk); #1;
        mode = 2'd2; m_ready = 1'b1;
        send_beat(32'h0000_0B10, 8'hEE, 1'b0, acc, w);
        send_beat(32'h0000_0B11, 8'hEE, 1'b1, acc, w);
        idle(25);
        checks++;
        if (rx_data.size() !== 18) begin errors++; $display("FAIL b2b_count: got %0d beats, want 18", rx_data.size()); end
        for (int i = 0; i < 18 && i < rx_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_user[i], rx_last[i]} !== {32'hB00 + i, 8'h3C, i == 17}) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: got data=%h user=%h last=%b, want data=%h user=3c last=%b",
                         i, rx_data[i], rx_user[i], rx_last[i], 32'hB00 + i, i == 17);
            end
        end
        checks++;
        if ({pkt, drop} !== {16'd3, 16'd2}) begin errors++; $display("FAIL b2b_counts: got pkt=%0d drop=%0d, want pkt=3 drop=2", pkt, drop); end
        mode = 2'd0;
    endtask

    task automatic test_reset_mid_packet();
        int acc, w;
        sel = 1'b0; mode = 2'd0; m_ready = 1'b1;
        send_beat(32'h0000_0C00, 8'h99, 1'b0, acc, w);
        s_data = 32'h0000_0C01; s_strb = 4'h1; s_last = 1'b0; s_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_last, ovf, m_data, m_strb, m_user, pkt, drop} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got rdy=%b vld=%b last=%b ovf=%b data=%h strb=%h user=%h pkt=%0d drop=%0d, want all 0",
                     s_ready, m_valid, m_last, ovf, m_data, m_strb, m_user, pkt, drop);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        clear_rx();
        for (int i = 0; i < 3; i++) send_beat(32'h0000_0D00 + 32'(i), i == 0 ? 8'h42 : 8'h00, i == 2, acc, w);
        idle(5);
        checks++;
        if (rx_data.size() !== 3) begin errors++; $display("FAIL midrst_count: got %0d beats, want 3", rx_data.size()); end
        for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_user[i], rx_last[i]} !== {32'hD00 + i, 8'h42, i == 2}) begin
                errors++;
                $display("FAIL midrst_beat[%0d]: got data=%h user=%h last=%b, want data=%h user=42 last=%b",
                         i, rx_data[i], rx_user[i], rx_last[i], 32'hD00 + i, i == 2);
            end
        end
        checks++;
        if ({pkt, drop} !== {16'd1, 16'd0}) begin errors++; $display("FAIL midrst_counts: got pkt=%0d drop=%0d, want pkt=1 drop=0", pkt, drop); end
    endtask

    initial begin
        test_reset();
        test_cut_through();
        test_store_forward();
        test_sink();
        test_overflow();
        test_back_to_back();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
